cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle instruction sequencer for the 8-bit CPU. It steps each instruction through IDLE → FETCH → DECODE → EXECUTE/MEM → FETCH, and issues the datapath strobes for PC, IR, register file, ALU muxes and RAM one phase at a time. It stalls on a RAM ready handshake and supports a HALT opcode with external resume. It sits between the instruction register's opcode field, ALU flags and RAM on one side, and the datapath control inputs on the other.

## Interface
- TIMEOUT_CYCLES, 15: maximum consecutive not-ready cycles tolerated in FETCH/MEM (only used with SEQ_TIMEOUT_EN).

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  4  opcode field of the current IR
- zero  in  1  ALU zero flag
- carry  in  1  ALU carry flag
- mem_ready  in  1  RAM access complete this cycle
- resume  in  1  leave HALT (pulse)
- alu_op  out  3  ALU operation
- regfile_we  out  1  register file write enable
- pc_en  out  1  PC increment
- pc_load  out  1  PC load (jump)
- ir_load  out  1  IR capture
- mem_we  out  1  RAM write
- mem_re  out  1  RAM read
- mem_addr_sel  out  1  RAM address source: 0 = PC, 1 = data address
- sel_mux_a  out  2  register write/ALU-A source select
- sel_mux_b  out  2  ALU-B source select
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high while in HALT
- bus_error  out  1  sticky RAM timeout flag

## Operation
- Opcodes: 0 NOP, 1 LDI, 2 MOV, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 JC, 8 LOAD, 9 STORE, F HALT. Opcodes A–E are treated as NOP.
- All outputs are Moore-style decodes of the state, plus opcode, flags and mem_ready in the listed states. Outputs default to 0.
- **IDLE**: entered on reset. Moves to FETCH on the first clock edge after rst falls.
- **FETCH**: mem_re=1, mem_addr_sel=0.
  - Waits while mem_ready=0.
  - On the mem_ready=1 cycle: ir_load=1, then go to DECODE.
- **DECODE**: no strobes.
  - Opcode F → HALT.
  - Opcodes 8/9 → MEM.
  - All others → EXECUTE.
- **EXECUTE**: one cycle, then FETCH.
  - NOP: pc_en.
  - LDI: regfile_we, sel_mux_a=01, pc_en.
  - MOV: regfile_we, sel_mux_a=00, pc_en.
  - ADD: regfile_we, alu_op=001, sel_mux_a=10, sel_mux_b=00, pc_en.
  - SUB: regfile_we, alu_op=010, pc_en.
  - JMP: pc_load.
  - JZ/JC: pc_load if the flag is 1 in this cycle, else pc_en.
- **MEM**: mem_addr_sel=1.
  - LOAD: mem_re=1. STORE: mem_we=1.
  - Strobes hold while mem_ready=0.
  - On the mem_ready=1 cycle: LOAD also asserts regfile_we and sel_mux_a=11. Both LOAD and STORE assert pc_en. Then go to FETCH.
- **HALT**: halted=1, all strobes 0.
  - resume=1 (with bus_error=0): pc_en=1 in that cycle, then FETCH.
  - resume is ignored in all other states.
- retire = pc_en | pc_load.
- pc_en and pc_load are never high together.
- mem_we and mem_re are never high together.

## Timing
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE, every output 0, timeout counter 0, bus_error 0.
  - An in-flight RAM access is abandoned.
- Latency with zero wait states (mem_ready tied 1):
  - Non-memory instruction: 3 cycles (FETCH, DECODE, EXECUTE).
  - LOAD/STORE: 3 cycles (FETCH, DECODE, MEM).
  - Each RAM wait cycle adds 1 cycle.
- Flags are sampled combinationally in the EXECUTE cycle only.
- mem_ready is ignored outside FETCH and MEM.
- First FETCH occurs 1 cycle after reset release.

## Configuration
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts consecutive mem_ready=0 cycles in FETCH/MEM.
  - The counter clears on mem_ready=1 and on any state change.
  - When the counter equals TIMEOUT_CYCLES and mem_ready=0, the next state is HALT with no strobes completed, and bus_error sets.
  - bus_error is sticky until rst and blocks resume.
- Undefined: no counter; waits are unbounded; bus_error is tied 0.

## Structure
- Package cpu_pkg holds:
  - opcode localparams;
  - state encoding (IDLE, FETCH, DECODE, EXECUTE, MEM, HALT);
  - alu_op codes;
  - mux select codes.
- Sub-module seq_exec_decode: combinational map from opcode + flags to the EXECUTE-phase strobe set. The top level holds the FSM, wait handling and timeout.

## Test plan
- mem_ready=1, program LDI, ADD, NOP → each retires 3 cycles apart; ADD EXECUTE shows alu_op=001, regfile_we=1, pc_en=1.
- JZ with zero=1, then with zero=0 → pc_load=1 then pc_en=1 in the respective EXECUTE cycles; pc_load and pc_en are never both 1.
- LOAD with mem_ready low for 3 MEM cycles → mem_re and mem_addr_sel held for 4 cycles; regfile_we, sel_mux_a=11 and pc_en appear only in the 4th; total 6 cycles.
- HALT opcode → halted=1 from the cycle after DECODE; resume pulse after 5 cycles → pc_en=1 that cycle, FETCH next.
- rst asserted mid-MEM (STORE) → mem_we drops to 0 immediately; state IDLE; first FETCH 1 cycle after release.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH → HALT after 5 FETCH cycles, bus_error=1, ir_load never asserted, resume ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package cpu_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LDI   = 4'h1;
   localparam logic [3:0] OP_MOV   = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_JMP   = 4'h5;
   localparam logic [3:0] OP_JZ    = 4'h6;
   localparam logic [3:0] OP_JC    = 4'h7;
   localparam logic [3:0] OP_LOAD  = 4'h8;
   localparam logic [3:0] OP_STORE = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEM,
      ST_HALT
   } state_t;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   localparam logic [1:0] MUXA_REG = 2'b00;
   localparam logic [1:0] MUXA_IMM = 2'b01;
   localparam logic [1:0] MUXA_ALU = 2'b10;
   localparam logic [1:0] MUXA_MEM = 2'b11;
   localparam logic [1:0] MUXB_REG = 2'b00;

endpackage

// File: rtl/seq_exec_decode.sv
// EXECUTE-phase strobe map: opcode plus ALU flags to the datapath controls
// that fire in that single cycle.
module seq_exec_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       carry,
   output logic [2:0] alu_op,
   output logic       regfile_we,
   output logic       pc_en,
   output logic       pc_load,
   output logic [1:0] sel_mux_a,
   output logic [1:0] sel_mux_b
);

   always_comb begin
      alu_op     = ALU_PASS;
      regfile_we = 1'b0;
      pc_en      = 1'b0;
      pc_load    = 1'b0;
      sel_mux_a  = MUXA_REG;
      sel_mux_b  = MUXB_REG;
      case (opcode)
         OP_LDI: begin
            regfile_we = 1'b1;
            sel_mux_a  = MUXA_IMM;
            pc_en      = 1'b1;
         end
         OP_MOV: begin
            regfile_we = 1'b1;
            sel_mux_a  = MUXA_REG;
            pc_en      = 1'b1;
         end
         OP_ADD: begin
            regfile_we = 1'b1;
            alu_op     = ALU_ADD;
            sel_mux_a  = MUXA_ALU;
            sel_mux_b  = MUXB_REG;
            pc_en      = 1'b1;
         end
         OP_SUB: begin
            regfile_we = 1'b1;
            alu_op     = ALU_SUB;
            pc_en      = 1'b1;
         end
         OP_JMP: pc_load = 1'b1;
         OP_JZ: begin
            pc_load = zero;
            pc_en   = ~zero;
         end
         OP_JC: begin
            pc_load = carry;
            pc_en   = ~carry;
         end
         // NOP and the unused A-E codes simply advance the PC
         default: pc_en = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer with RAM ready stalls and HALT/resume.
// Define SEQ_TIMEOUT_EN to bound RAM waits and raise a sticky bus_error.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       carry,
   input  logic       mem_ready,
   input  logic       resume,
   output logic [2:0] alu_op,
   output logic       regfile_we,
   output logic       pc_en,
   output logic       pc_load,
   output logic       ir_load,
   output logic       mem_we,
   output logic       mem_re,
   output logic       mem_addr_sel,
   output logic [1:0] sel_mux_a,
   output logic [1:0] sel_mux_b,
   output logic       retire,
   output logic       halted,
   output logic       bus_error
);

   state_t     state;
   logic       timeout_hit;
   logic [2:0] ex_alu_op;
   logic       ex_regfile_we, ex_pc_en, ex_pc_load;
   logic [1:0] ex_mux_a, ex_mux_b;

   seq_exec_decode u_exec_decode (
      .opcode     (opcode),
      .zero       (zero),
      .carry      (carry),
      .alu_op     (ex_alu_op),
      .regfile_we (ex_regfile_we),
      .pc_en      (ex_pc_en),
      .pc_load    (ex_pc_load),
      .sel_mux_a  (ex_mux_a),
      .sel_mux_b  (ex_mux_b)
   );

`ifdef SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_count;
   logic          bus_error_q;

   assign timeout_hit = (state == ST_FETCH || state == ST_MEM) && !mem_ready &&
                        (wait_count == CW'(TIMEOUT_CYCLES));
   assign bus_error   = bus_error_q;

   // Counts only uninterrupted stalls; any ready or state change restarts it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_count  <= '0;
         bus_error_q <= 1'b0;
      end else begin
         if ((state == ST_FETCH || state == ST_MEM) && !mem_ready && !timeout_hit)
            wait_count <= wait_count + 1'b1;
         else
            wait_count <= '0;
         if (timeout_hit)
            bus_error_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_error   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    state <= ST_FETCH;
            ST_FETCH: begin
               if (timeout_hit)    state <= ST_HALT;
               else if (mem_ready) state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (opcode == OP_HALT)
                  state <= ST_HALT;
               else if (opcode == OP_LOAD || opcode == OP_STORE)
                  state <= ST_MEM;
               else
                  state <= ST_EXECUTE;
            end
            ST_EXECUTE: state <= ST_FETCH;
            ST_MEM: begin
               if (timeout_hit)    state <= ST_HALT;
               else if (mem_ready) state <= ST_FETCH;
            end
            ST_HALT: begin
               if (resume && !bus_error) state <= ST_FETCH;
            end
            default:    state <= ST_IDLE;
         endcase
      end
   end

   // Strobes are decoded from the current state so reset clears them at once
   always_comb begin
      alu_op       = ALU_PASS;
      regfile_we   = 1'b0;
      pc_en        = 1'b0;
      pc_load      = 1'b0;
      ir_load      = 1'b0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_addr_sel = 1'b0;
      sel_mux_a    = MUXA_REG;
      sel_mux_b    = MUXB_REG;
      halted       = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_re  = 1'b1;
            ir_load = mem_ready;
         end
         ST_EXECUTE: begin
            alu_op     = ex_alu_op;
            regfile_we = ex_regfile_we;
            pc_en      = ex_pc_en;
            pc_load    = ex_pc_load;
            sel_mux_a  = ex_mux_a;
            sel_mux_b  = ex_mux_b;
         end
         ST_MEM: begin
            mem_addr_sel = 1'b1;
            mem_re       = (opcode == OP_LOAD);
            mem_we       = (opcode != OP_LOAD);
            if (mem_ready) begin
               pc_en = 1'b1;
               if (opcode == OP_LOAD) begin
                  regfile_we = 1'b1;
                  sel_mux_a  = MUXA_MEM;
               end
            end
         end
         ST_HALT: begin
            halted = 1'b1;
            pc_en  = resume && !bus_error;
         end
         default: ;
      endcase
      retire = pc_en | pc_load;
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: each cycle's inputs and expected output
// vector are queued by the scenario tasks, then replayed and compared.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       zero = 1'b0, carry = 1'b0, mem_ready = 1'b0, resume = 1'b0;
   logic [2:0] alu_op;
   logic       regfile_we, pc_en, pc_load, ir_load, mem_we, mem_re, mem_addr_sel;
   logic [1:0] sel_mux_a, sel_mux_b;
   logic       retire, halted, bus_error;

   int compared   = 0;
   int mismatched = 0;

   // {alu_op, regfile_we, pc_en, pc_load, ir_load, mem_we, mem_re,
   //  mem_addr_sel, sel_mux_a, sel_mux_b, retire, halted, bus_error}
   localparam logic [16:0] NONE = 17'h00000;
   localparam logic [16:0] AADD = 17'h04000;
   localparam logic [16:0] ASUB = 17'h08000;
   localparam logic [16:0] RF   = 17'h02000;
   localparam logic [16:0] PC   = 17'h01000;
   localparam logic [16:0] PL   = 17'h00800;
   localparam logic [16:0] IR   = 17'h00400;
   localparam logic [16:0] WE   = 17'h00200;
   localparam logic [16:0] RE   = 17'h00100;
   localparam logic [16:0] AS   = 17'h00080;
   localparam logic [16:0] MA1  = 17'h00020;
   localparam logic [16:0] MA2  = 17'h00040;
   localparam logic [16:0] MA3  = 17'h00060;
   localparam logic [16:0] RT   = 17'h00004;
   localparam logic [16:0] HL   = 17'h00002;
   localparam logic [16:0] BE   = 17'h00001;

   logic [16:0] obs;
   assign obs = {alu_op, regfile_we, pc_en, pc_load, ir_load, mem_we, mem_re,
                 mem_addr_sel, sel_mux_a, sel_mux_b, retire, halted, bus_error};

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic        z, c, rdy, res;
      logic [16:0] exp;
   } step_t;

   step_t sbq[$];

   cpu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .carry(carry),
      .mem_ready(mem_ready), .resume(resume), .alu_op(alu_op),
      .regfile_we(regfile_we), .pc_en(pc_en), .pc_load(pc_load),
      .ir_load(ir_load), .mem_we(mem_we), .mem_re(mem_re),
      .mem_addr_sel(mem_addr_sel), .sel_mux_a(sel_mux_a),
      .sel_mux_b(sel_mux_b), .retire(retire), .halted(halted),
      .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic push(input string n, input logic [3:0] op, input logic z,
                       input logic c, input logic rdy, input logic res,
                       input logic [16:0] e);
      step_t s;
      s.name = n; s.op = op; s.z = z; s.c = c; s.rdy = rdy; s.res = res; s.exp = e;
      sbq.push_back(s);
   endtask

   // One full instruction with zero wait states: FETCH, DECODE, EXECUTE
   task automatic push_instr(input string n, input logic [3:0] op, input logic z,
                             input logic c, input logic [16:0] ex);
      push({n, "_fetch"},  op, z, c, 1'b1, 1'b0, RE | IR);
      push({n, "_decode"}, op, z, c, 1'b1, 1'b0, NONE);
      push({n, "_exec"},   op, z, c, 1'b1, 1'b0, ex);
   endtask

   task automatic run_queue();
      step_t s;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         @(negedge clk);
         opcode = s.op; zero = s.z; carry = s.c; mem_ready = s.rdy; resume = s.res;
         #1;
         compared++;
         if (obs !== s.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h want %h", s.name, obs, s.exp);
         end
      end
   endtask

   task automatic check_now(input string n, input logic [16:0] e);
      compared++;
      if (obs !== e) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h want %h", n, obs, e);
      end
   endtask

   // Leaves the DUT in IDLE; the next queued step lands in the first FETCH
   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1; opcode = 4'h0; zero = 1'b0; carry = 1'b0;
      mem_ready = 1'b0; resume = 1'b0;
      #1;
      check_now("reset_held", NONE);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_now("reset_idle", NONE);
   endtask

   task automatic test_reset();
      reset_dut();
      push("first_fetch_wait", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, RE);
      push("first_fetch_rdy",  4'h0, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      run_queue();
   endtask

   task automatic test_alu_program();
      reset_dut();
      push_instr("ldi", 4'h1, 1'b0, 1'b0, RF | MA1 | PC | RT);
      push_instr("add", 4'h3, 1'b0, 1'b0, AADD | RF | MA2 | PC | RT);
      push_instr("nop", 4'h0, 1'b0, 1'b0, PC | RT);
      push_instr("mov", 4'h2, 1'b0, 1'b0, RF | PC | RT);
      push_instr("sub", 4'h4, 1'b0, 1'b0, ASUB | RF | PC | RT);
      push_instr("op_b_nop", 4'hB, 1'b1, 1'b1, PC | RT);
      run_queue();
   endtask

   task automatic test_branches();
      reset_dut();
      push_instr("jz_taken",  4'h6, 1'b1, 1'b0, PL | RT);
      push_instr("jz_not",    4'h6, 1'b0, 1'b1, PC | RT);
      push_instr("jc_taken",  4'h7, 1'b0, 1'b1, PL | RT);
      push_instr("jc_not",    4'h7, 1'b1, 1'b0, PC | RT);
      push_instr("jmp",       4'h5, 1'b0, 1'b0, PL | RT);
      run_queue();
   endtask

   task automatic test_load_wait();
      reset_dut();
      push("load_fetch",  4'h8, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      push("load_decode", 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
      for (int i = 0; i < 3; i++)
         push("load_mem_wait", 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, RE | AS);
      push("load_mem_done", 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, RE | AS | RF | MA3 | PC | RT);
      push("load_next_fetch", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      run_queue();
   endtask

   task automatic test_store_back_to_back();
      reset_dut();
      push("store_fetch",  4'h9, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      push("store_decode", 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, NONE);
      push("store_mem",    4'h9, 1'b0, 1'b0, 1'b1, 1'b0, WE | AS | PC | RT);
      push("load_fetch",   4'h8, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      push("load_decode",  4'h8, 1'b0, 1'b0, 1'b1, 1'b0, NONE);
      push("load_mem",     4'h8, 1'b0, 1'b0, 1'b1, 1'b0, RE | AS | RF | MA3 | PC | RT);
      run_queue();
   endtask

   task automatic test_halt_resume();
      reset_dut();
      push("halt_fetch",  4'hF, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      push("decode_resume_ignored", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, NONE);
      for (int i = 0; i < 5; i++)
         push("halt_wait", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, HL);
      push("halt_resume", 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, HL | PC | RT);
      push("after_resume_fetch", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      push("nop_decode_resume", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, NONE);
      push("nop_exec_resume",   4'h0, 1'b0, 1'b0, 1'b1, 1'b1, PC | RT);
      run_queue();
   endtask

   task automatic test_reset_mid_mem();
      reset_dut();
      push("st_fetch",  4'h9, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      push("st_decode", 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, NONE);
      push("st_mem_wait", 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, WE | AS);
      run_queue();
      #2;
      rst = 1'b1;
      #1;
      check_now("mid_mem_reset_drop", NONE);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_now("mid_mem_reset_idle", NONE);
      push("post_reset_fetch", 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      run_queue();
   endtask

`ifdef SEQ_TIMEOUT_EN
   task automatic test_timeout();
      reset_dut();
      for (int i = 0; i < 5; i++)
         push("to_fetch_stall", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, RE);
      push("to_halt",        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, HL | BE);
      push("to_resume_ign",  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, HL | BE);
      push("to_still_halt",  4'h0, 1'b0, 1'b0, 1'b1, 1'b0, HL | BE);
      run_queue();
      reset_dut();
      push("to_cleared_fetch", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      run_queue();
   endtask
`else
   task automatic test_unbounded_wait();
      reset_dut();
      for (int i = 0; i < 20; i++)
         push("long_fetch_stall", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, RE);
      push("long_fetch_done", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, RE | IR);
      run_queue();
   endtask
`endif

   initial begin
      test_reset();
      test_alu_program();
      test_branches();
      test_load_wait();
      test_store_back_to_back();
      test_halt_resume();
      test_reset_mid_mem();
`ifdef SEQ_TIMEOUT_EN
      test_timeout();
`else
      test_unbounded_wait();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
